// File: rtl/chrom_serial_loader_if.sv
// Byte-stream link from the GA host into the chromosome loader.
// The master drives data/valid, the slave answers with ready.
interface chrom_serial_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/chrom_serial_loader.sv
// Unpacks a checksummed genotype frame into shadow registers and commits it atomically.
// Optional mid-frame idle abort is built when CHROM_TIMEOUT_EN is defined.
module chrom_serial_loader #(
  parameter int ROW         = 2,
  parameter int COL         = 2,
  parameter int OUT         = 2,
  parameter int BITS_SEL    = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int TOTAL      = ROW * COL,
  localparam int SEL_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1,
  localparam int IN_W       = 4 * BITS_SEL,
  localparam int IN_BYTES   = (IN_W + 7) / 8,
  localparam int OUT_BYTES  = (SEL_W + 7) / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  chrom_serial_loader_if.slave      strm,
  output logic [TOTAL*16-1:0]       saidas_LE,
  output logic [TOTAL*IN_W-1:0]     in_chrom,
  output logic [OUT*SEL_W-1:0]      out_chrom,
  output logic                      cfg_valid,
  output logic                      err,
  output logic [1:0]                err_cause,
  output logic                      busy
);

  localparam int TT_BYTES  = TOTAL * 2;
  localparam int IN_TOT    = TOTAL * IN_BYTES;
  localparam int OUT_TOT   = OUT * OUT_BYTES;
  localparam int MAXF      = (TT_BYTES > IN_TOT) ? ((TT_BYTES > OUT_TOT) ? TT_BYTES : OUT_TOT)
                                                 : ((IN_TOT > OUT_TOT) ? IN_TOT : OUT_TOT);
  localparam int CNT_W     = $clog2(MAXF + 1);
  localparam int OSEL_RAW  = 8 * OUT_BYTES;

  localparam logic [CNT_W-1:0]  TT_LAST  = CNT_W'(TT_BYTES - 1);
  localparam logic [CNT_W-1:0]  IN_LAST  = CNT_W'(IN_TOT - 1);
  localparam logic [CNT_W-1:0]  OUT_LAST = CNT_W'(OUT_TOT - 1);
  localparam logic [OSEL_RAW:0] TOTAL_V  = (OSEL_RAW + 1)'(TOTAL);
  localparam logic [7:0]        HDR      = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TT,
    S_INSEL,
    S_OUTSEL,
    S_CHK,
    S_COMMIT
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             csum;
  logic                   ready;
  logic                   acc;
  logic [TT_BYTES*8-1:0]  sh_tt;
  logic [IN_TOT*8-1:0]    sh_in;
  logic [OUT_TOT*8-1:0]   sh_out;
  logic [TOTAL*IN_W-1:0]  in_ext;
  logic [OUT*SEL_W-1:0]   out_ext;
  logic                   range_bad;

  assign strm.s_ready = ready;
  assign acc          = strm.s_valid && ready;

  // Range is judged on the full raw selector bytes, before the unused high bits are dropped.
  always_comb begin
    in_ext    = '0;
    out_ext   = '0;
    range_bad = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      in_ext[IN_W*i +: IN_W] = sh_in[8*IN_BYTES*i +: IN_W];
    end
    for (int k = 0; k < OUT; k++) begin
      out_ext[SEL_W*k +: SEL_W] = sh_out[OSEL_RAW*k +: SEL_W];
      if ({1'b0, sh_out[OSEL_RAW*k +: OSEL_RAW]} >= TOTAL_V) begin
        range_bad = 1'b1;
      end
    end
  end

`ifdef CHROM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      csum      <= '0;
      ready     <= 1'b1;
      sh_tt     <= '0;
      sh_in     <= '0;
      sh_out    <= '0;
      saidas_LE <= '0;
      in_chrom  <= '0;
      out_chrom <= '0;
      cfg_valid <= 1'b0;
      err       <= 1'b0;
      err_cause <= 2'd0;
      busy      <= 1'b0;
`ifdef CHROM_TIMEOUT_EN
      tmo       <= '0;
`endif
    end else begin
      cfg_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          ready <= 1'b1;
          if (acc && strm.s_data == HDR) begin
            cnt   <= '0;
            csum  <= '0;
            busy  <= 1'b1;
            state <= S_TT;
          end
        end
        S_TT: begin
          if (acc) begin
            for (int b = 0; b < TT_BYTES; b++) begin
              if (cnt == CNT_W'(b)) sh_tt[8*b +: 8] <= strm.s_data;
            end
            csum <= csum ^ strm.s_data;
            if (cnt == TT_LAST) begin
              cnt   <= '0;
              state <= S_INSEL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_INSEL: begin
          if (acc) begin
            for (int b = 0; b < IN_TOT; b++) begin
              if (cnt == CNT_W'(b)) sh_in[8*b +: 8] <= strm.s_data;
            end
            csum <= csum ^ strm.s_data;
            if (cnt == IN_LAST) begin
              cnt   <= '0;
              state <= S_OUTSEL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_OUTSEL: begin
          if (acc) begin
            for (int b = 0; b < OUT_TOT; b++) begin
              if (cnt == CNT_W'(b)) sh_out[8*b +: 8] <= strm.s_data;
            end
            csum <= csum ^ strm.s_data;
            if (cnt == OUT_LAST) begin
              cnt   <= '0;
              state <= S_CHK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_CHK: begin
          // Verdict is registered here so cfg_valid/err are visible during the commit cycle.
          if (acc) begin
            if (strm.s_data != csum) begin
              err       <= 1'b1;
              err_cause <= 2'd1;
            end else if (range_bad) begin
              err       <= 1'b1;
              err_cause <= 2'd2;
            end else begin
              cfg_valid <= 1'b1;
            end
            busy  <= 1'b0;
            ready <= 1'b0;
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (cfg_valid) begin
            saidas_LE <= sh_tt;
            in_chrom  <= in_ext;
            out_chrom <= out_ext;
          end
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase

`ifdef CHROM_TIMEOUT_EN
      if (state inside {S_TT, S_INSEL, S_OUTSEL, S_CHK}) begin
        if (acc) begin
          tmo <= '0;
        end else if (tmo == TMO_LAST) begin
          tmo       <= '0;
          err       <= 1'b1;
          err_cause <= 2'd3;
          busy      <= 1'b0;
          cnt       <= '0;
          state     <= S_IDLE;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else begin
        tmo <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Directed frames against hand-computed tables, truth-table words and selector fields.
module tb_chrom_serial_loader;

  typedef logic [7:0] frame_t [16];

  logic        clk;
  logic        rst;
  logic [63:0] saidas_LE;
  logic [31:0] in_chrom;
  logic [3:0]  out_chrom;
  logic        cfg_valid;
  logic        err;
  logic [1:0]  err_cause;
  logic        busy;

  int n_chk;
  int n_err;
  int err_cnt;
  int cfg_cnt;
  int err_snap;
  int cfg_snap;

  chrom_serial_loader_if sif ();

  chrom_serial_loader dut (
    .clk       (clk),
    .rst       (rst),
    .strm      (sif),
    .saidas_LE (saidas_LE),
    .in_chrom  (in_chrom),
    .out_chrom (out_chrom),
    .cfg_valid (cfg_valid),
    .err       (err),
    .err_cause (err_cause),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_cnt++;
      if (cfg_valid) cfg_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    sif.s_data  = b;
    sif.s_valid = 1'b1;
    while (!sif.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_wait", {63'd0, sif.s_ready}, 64'd1);
    @(negedge clk);
  endtask

  task automatic send_range(input frame_t f, input int lo, input int hi, input bit thr);
    for (int i = lo; i <= hi; i++) begin
      send_byte(f[i]);
      if (thr && i < hi) begin
        sif.s_valid = 1'b0;
        @(negedge clk);
      end
    end
    sif.s_valid = 1'b0;
  endtask

  // Entered at the negedge of the commit cycle.
  task automatic expect_end(input string tag, input bit ok, input logic [1:0] cause,
                            input logic [63:0] tt, input logic [31:0] ins, input logic [3:0] outs);
    check({tag, "_cfg"},   {63'd0, cfg_valid}, {63'd0, ok});
    check({tag, "_err"},   {63'd0, err}, {63'd0, !ok});
    check({tag, "_cause"}, {62'd0, err_cause}, {62'd0, cause});
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_rdy0"},  {63'd0, sif.s_ready}, 64'd0);
    @(negedge clk);
    check({tag, "_tt"},    saidas_LE, tt);
    check({tag, "_in"},    {32'd0, in_chrom}, {32'd0, ins});
    check({tag, "_out"},   {60'd0, out_chrom}, {60'd0, outs});
    check({tag, "_pulse"}, {62'd0, cfg_valid, err}, 64'd0);
    check({tag, "_rdy1"},  {63'd0, sif.s_ready}, 64'd1);
  endtask

  frame_t good  = '{8'hA5, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h98};
  frame_t badck = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h59};
  frame_t rng   = '{8'hA5, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h9F};
  frame_t rngck = '{8'hA5, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h9E};
  frame_t f2    = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12,
                    8'h00, 8'h00, 8'h00, 8'hE4, 8'h01, 8'h02, 8'h64};

  localparam logic [63:0] GOOD_TT = 64'h0000_0000_0000_8000;
  localparam logic [63:0] F2_TT   = 64'h1234_0000_00A5_0000;

  initial begin
    n_chk = 0;
    n_err = 0;
    err_cnt = 0;
    cfg_cnt = 0;
    rst = 1'b1;
    sif.s_data  = 8'h00;
    sif.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_tt",    saidas_LE, 64'd0);
    check("rst_in",    {32'd0, in_chrom}, 64'd0);
    check("rst_out",   {60'd0, out_chrom}, 64'd0);
    check("rst_flags", {60'd0, cfg_valid, err, busy, sif.s_ready}, 64'h1);
    check("rst_cause", {62'd0, err_cause}, 64'd0);

    // Good frame; busy must rise right after the header.
    err_snap = err_cnt;
    send_byte(good[0]);
    check("good_busy", {63'd0, busy}, 64'd1);
    send_range(good, 1, 15, 1'b0);
    expect_end("good", 1'b1, 2'd0, GOOD_TT, 32'h1B, 4'b1100);
    check("good_noerr", err_cnt, err_snap);

    send_range(badck, 0, 15, 1'b0);
    expect_end("badck", 1'b0, 2'd1, GOOD_TT, 32'h1B, 4'b1100);

    send_range(rng, 0, 15, 1'b0);
    expect_end("range", 1'b0, 2'd2, GOOD_TT, 32'h1B, 4'b1100);

    send_range(rngck, 0, 15, 1'b0);
    expect_end("rngck", 1'b0, 2'd1, GOOD_TT, 32'h1B, 4'b1100);

    // Payload 0xA5 is data; err_cause keeps its last value across a good commit.
    send_range(f2, 0, 15, 1'b0);
    expect_end("f2", 1'b1, 2'd1, F2_TT, 32'hE400_0000, 4'b1001);

    // Junk ahead of the header and a throttled stream.
    cfg_snap = cfg_cnt;
    err_snap = err_cnt;
    send_byte(8'h11);
    sif.s_valid = 1'b0;
    @(negedge clk);
    send_byte(8'h22);
    check("junk_idle", {63'd0, busy}, 64'd0);
    sif.s_valid = 1'b0;
    @(negedge clk);
    send_range(good, 0, 15, 1'b1);
    expect_end("thr", 1'b1, 2'd1, GOOD_TT, 32'h1B, 4'b1100);
    check("thr_ncfg", cfg_cnt, cfg_snap + 1);
    check("thr_nerr", err_cnt, err_snap);

    // Reset after five bytes of a frame.
    send_range(f2, 0, 4, 1'b0);
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_tt",    saidas_LE, 64'd0);
    check("mrst_sel",   {28'd0, in_chrom, out_chrom}, 64'd0);
    check("mrst_flags", {60'd0, cfg_valid, err, busy, sif.s_ready}, 64'h1);
    check("mrst_cause", {62'd0, err_cause}, 64'd0);

    // Good frame with a long mid-frame stall: no abort without the timeout build.
    err_snap = err_cnt;
    send_range(good, 0, 3, 1'b0);
    repeat (40) @(negedge clk);
    check("stall_busy", {63'd0, busy}, 64'd1);
    check("stall_nerr", err_cnt, err_snap);
    send_range(good, 4, 15, 1'b0);
    expect_end("post", 1'b1, 2'd0, GOOD_TT, 32'h1B, 4'b1100);

    // Header accepted in the cycle right after commit.
    send_range(f2, 0, 15, 1'b0);
    check("b2b_cfg", {63'd0, cfg_valid}, 64'd1);
    send_byte(8'hA5);
    check("b2b_out", {60'd0, out_chrom}, {60'd0, 4'b1001});
    check("b2b_busy", {63'd0, busy}, 64'd1);
    send_range(good, 1, 15, 1'b0);
    expect_end("b2b", 1'b1, 2'd0, GOOD_TT, 32'h1B, 4'b1100);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/chrom_serial_loader.md
Name: chrom_serial_loader

Overview:
- Serial-side writer for the evolvable logic-element array.
- Receives a byte-stream genotype frame from the GA host link. Unpacks it into shadow registers: per-cell truth tables, input-mux selectors, output selectors.
- Commits all three atomically to the active configuration only after the checksum and range checks pass. The array never sees a partially loaded chromosome.

Parameters:
- ROW, 2, element rows
- COL, 2, element columns
- OUT, 2, circuit outputs
- BITS_SEL, 2, selector width per element input (4 inputs per element)
- TIMEOUT_CYC, 1024, idle cycles mid-frame before abort (used only with the optional feature)
- Derived, not overridable:
  - TOTAL = ROW*COL
  - SEL_W = max(1, $clog2(TOTAL))
  - IN_BYTES = ceil(4*BITS_SEL/8)
  - OUT_BYTES = ceil(SEL_W/8)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_ready  out  1  loader accepts byte
- saidas_LE  out  TOTAL*16  active truth tables; cell i = r*COL+c at bits [16i+15:16i]
- in_chrom  out  TOTAL*4*BITS_SEL  active input selectors; cell i at [4*BITS_SEL*i +: 4*BITS_SEL]
- out_chrom  out  OUT*SEL_W  active output selectors; output k at [SEL_W*k +: SEL_W]
- cfg_valid  out  1  one-cycle pulse on commit
- err  out  1  one-cycle pulse on frame rejection
- err_cause  out  2  1=checksum, 2=out_chrom range, 3=timeout; holds until the next err
- busy  out  1  high from header accept through commit/reject

Behaviour:
- Reset:
  - All active and shadow registers are 0. cfg_valid=0, err=0, err_cause=0, busy=0.
  - State = IDLE. s_ready=1 in the cycle after reset deasserts.
  - Reset mid-frame discards the frame; the active configuration is zeroed.
- A byte transfers when s_valid && s_ready on a rising clk edge.
- Frame format, in this order:
  - Header 0xA5.
  - TT: TOTAL*2 bytes, cell 0 first, low byte first.
  - INSEL: TOTAL*IN_BYTES bytes, little-endian per cell. Bits above 4*BITS_SEL are ignored. Within a cell, selector j (element input j) occupies bits [BITS_SEL*j +: BITS_SEL].
  - OUTSEL: OUT*OUT_BYTES bytes, little-endian per output. Bits above SEL_W are ignored.
  - Checksum: XOR of all payload bytes (header excluded).
- FSM: IDLE -> TT -> INSEL -> OUTSEL -> CHK -> COMMIT -> IDLE.
  - IDLE: s_ready=1. Non-0xA5 bytes are consumed and dropped. On 0xA5, clear the byte counter and running XOR, set busy, go to TT.
  - TT, INSEL, OUTSEL: a byte counter indexes the shadow field. Advance to the next state after that field's last byte.
  - OUTSEL range check: any selector value >= TOTAL sets a sticky range flag. The remaining bytes are still consumed.
  - CHK: accept the checksum byte, go to COMMIT.
  - COMMIT: one cycle, s_ready=0.
    - If XOR matches and the range flag is clear: copy shadow to active, pulse cfg_valid.
    - If the checksum mismatches: pulse err, err_cause=1. Checksum takes priority over range.
    - If only the range flag is set: pulse err, err_cause=2.
    - busy drops the same cycle; return to IDLE.
- The active registers change only in the COMMIT cycle. New values are visible at outputs the cycle after COMMIT. Latency from checksum byte accept to cfg_valid is 1 cycle.
- A 0xA5 byte inside the payload is data, not a resync.
- Back-to-back frames: a header may be accepted in the cycle after COMMIT.

Optional Feature:
- Macro CHROM_TIMEOUT_EN.
- Defined: a counter runs while state is TT/INSEL/OUTSEL/CHK. It clears on each accepted byte. When it reaches TIMEOUT_CYC, the loader pulses err with err_cause=3, clears busy, returns to IDLE, and leaves the active configuration untouched.
- Undefined: no counter. The loader waits indefinitely mid-frame, and err_cause=3 is never produced.

Test Plan:
- Good frame (default parameters):
  - Stimulus: A5 | 00 80 00 00 00 00 00 00 | 1B 00 00 00 | 00 03 | 98.
  - Response: cfg_valid 1 cycle after the 98 byte; saidas_LE[15:0]=0x8000; in_chrom[7:0]=0x1B; out_chrom=4'b1100; err never asserted.
- Bad checksum: same frame with checksum 99 -> err pulse, err_cause=1, outputs retain the previous values.
- Range: out_chrom byte 0x04 with the checksum recomputed -> err, err_cause=2, no commit. Combined with a bad checksum -> err_cause=1.
- Junk and throttling: bytes 11 22 before the header, s_valid toggled every other cycle -> junk dropped, frame commits identically to the good-frame case.
- Reset at byte 5 of a frame, then a good frame -> outputs 0 after reset, then correct commit, busy sequence correct.
- CHROM_TIMEOUT_EN with TIMEOUT_CYC=16: stall 16 cycles after byte 3 -> err, err_cause=3, IDLE; a following good frame commits.
